// File: rtl/moore_cnt_fsm.sv
// -----------------------------------------------------------------------------
// moore_cnt_fsm
//   Parametrised Moore counter used as a generic sequencer / step counter.
//   Counts modulo MODULO, up or down. It also has a synchronous clear, a
//   parallel load that clamps to MODULO-1, and a saturate or wrap mode at the
//   ends. Every output is a function of registered state only.
//
//   Optional feature (compile-time macro MOORE_CNT_GRAY_EN):
//     defined   : out is a registered Gray encoding of the binary state.
//     undefined : out is the binary state itself, with no extra register.
//
// Parameters
//   WIDTH    : state/output width in bits, 1..16
//   MODULO   : number of states 0..MODULO-1, 2..2^WIDTH
//   SATURATE : 0 = wrap at the ends, 1 = hold at the ends
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   en        in   count enable
//   dir       in   1 = count up, 0 = count down
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous parallel load (beats en)
//   load_val  in   value to load, clamped to MODULO-1
//   out       out  current state (binary, or Gray with the macro)
//   tc_hi     out  state == MODULO-1
//   tc_lo     out  state == 0
//   wrap      out  registered one-cycle pulse after a wrap event
// -----------------------------------------------------------------------------
module moore_cnt_fsm #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc_hi,
  output logic             tc_lo,
  output logic             wrap
);

  // Compare in WIDTH+1 bits so that MODULO == 2^WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_ST = WIDTH'(MODULO - 1);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLR,
    ACT_LOAD,
    ACT_UP,
    ACT_DOWN
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] st_q, st_d;
  logic             wrap_q, wrap_d;
  logic             st_valid;

  // Resolve the per-cycle action with clr > load > en priority.
  always_comb begin
    act = ACT_HOLD;
    if (clr)       act = ACT_CLR;
    else if (load) act = ACT_LOAD;
    else if (en)   act = dir ? ACT_UP : ACT_DOWN;
  end

  assign st_valid = ({1'b0, st_q} < MOD_X);

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    st_d   = st_q;
    wrap_d = 1'b0;
    unique case (act)
      ACT_CLR:  st_d = '0;
      ACT_LOAD: st_d = ({1'b0, load_val} < MOD_X) ? load_val : MAX_ST;
      default: begin
        if (!st_valid) begin
          // An unreachable state, such as one left by an upset, recovers
          // to 0 on the next update.
          st_d = '0;
        end else if (act == ACT_UP) begin
          if (st_q != MAX_ST) begin
            st_d = st_q + 1'b1;
          end else if (!SATURATE) begin
            st_d   = '0;
            wrap_d = 1'b1;
          end
        end else if (act == ACT_DOWN) begin
          if (st_q != '0) begin
            st_d = st_q - 1'b1;
          end else if (!SATURATE) begin
            st_d   = MAX_ST;
            wrap_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that all
    // registers sample their inputs from the same pre-edge values.
    if (rst) begin
      st_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef MOORE_CNT_GRAY_EN
  // The Gray encoding is registered from st_d, so it changes on the same
  // edge as st_q and out still depends only on registered state.
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gray_q <= '0;
    else     gray_q <= st_d ^ (st_d >> 1);
  end

  assign out = gray_q;
`else
  assign out = st_q;
`endif

  // The terminal counts decode the binary state in both builds.
  assign tc_hi = (st_q == MAX_ST);
  assign tc_lo = (st_q == '0);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_moore_cnt_fsm.sv
// -----------------------------------------------------------------------------
// tb_moore_cnt_fsm
//   Self-checking bench for moore_cnt_fsm. There are three instances:
//     d0 : WIDTH=4, MODULO=10, wrap
//     d1 : WIDTH=4, MODULO=10, saturate
//     d2 : WIDTH=4, MODULO=16, wrap (full binary range)
//   Stimulus pushes the expected state for a selected instance into a
//   scoreboard queue. A monitor pops one entry per clock edge and compares
//   out, tc_hi, tc_lo and wrap. Checks of the asynchronous reset are made
//   directly between edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_moore_cnt_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] out_a [3];
  logic       tch_a [3];
  logic       tcl_a [3];
  logic       wrp_a [3];

  int modulo_of [3] = '{10, 10, 16};

  always #5 clk = ~clk;

  moore_cnt_fsm #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[0]), .tc_hi(tch_a[0]), .tc_lo(tcl_a[0]),
    .wrap(wrp_a[0])
  );

  moore_cnt_fsm #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[1]), .tc_hi(tch_a[1]), .tc_lo(tcl_a[1]),
    .wrap(wrp_a[1])
  );

  moore_cnt_fsm #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .out(out_a[2]), .tc_hi(tch_a[2]), .tc_lo(tcl_a[2]),
    .wrap(wrp_a[2])
  );

  typedef struct {
    int         sel;
    logic [3:0] st;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected out encoding for a given binary state.
  function automatic logic [3:0] enc(input logic [3:0] s);
`ifdef MOORE_CNT_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  // Monitor: the outputs settle 1 ns after each rising edge; compare them
  // against the oldest expectation.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".out"},   out_a[e.sel], enc(e.st));
        check({e.tag, ".tc_hi"}, tch_a[e.sel], e.st == 4'(modulo_of[e.sel] - 1));
        check({e.tag, ".tc_lo"}, tcl_a[e.sel], e.st == 4'd0);
        check({e.tag, ".wrap"},  wrp_a[e.sel], e.wrap);
      end
    end
  end

  // Drive one cycle of inputs and queue the expected state after the edge.
  task automatic step(input int sel, input logic e_, input logic d_,
                      input logic c_, input logic l_, input logic [3:0] lv,
                      input logic [3:0] xst, input logic xw, input string tag);
    exp_t e;
    @(negedge clk);
    en = e_; dir = d_; clr = c_; load = l_; load_val = lv;
    e.sel = sel; e.st = xst; e.wrap = xw; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Assert reset between edges and check all instances immediately, before
  // any clock edge occurs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.d%0d.out", tag, i),   out_a[i], 4'd0);
      check($sformatf("%s.d%0d.tc_lo", tag, i), tcl_a[i], 1'b1);
      check($sformatf("%s.d%0d.tc_hi", tag, i), tch_a[i], 1'b0);
      check($sformatf("%s.d%0d.wrap", tag, i),  wrp_a[i], 1'b0);
    end
    en = 1'b0; clr = 1'b0; load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Up count with wrap: 1..9, 0 (wrap), 1, 2
    do_reset("rstA");
    for (int i = 1; i <= 12; i++)
      step(0, 1, 1, 0, 0, 4'd0, 4'(i % 10), i == 10, $sformatf("up%0d", i));

    // Down count from 0: 9 (wrap), 8, 7
    do_reset("rstB");
    step(0, 1, 0, 0, 0, 4'd0, 4'd9, 1'b1, "dn1");
    step(0, 1, 0, 0, 0, 4'd0, 4'd8, 1'b0, "dn2");
    step(0, 1, 0, 0, 0, 4'd0, 4'd7, 1'b0, "dn3");

    // Load, clamp, priority, hold, direction change, clr after wrap
    step(0, 0, 0, 0, 1, 4'd13, 4'd9, 1'b0, "ld13");
    step(0, 1, 1, 0, 1, 4'd5,  4'd5, 1'b0, "ld5en");
    step(0, 0, 0, 0, 1, 4'd10, 4'd9, 1'b0, "ld10");
    step(0, 1, 1, 1, 1, 4'd3,  4'd0, 1'b0, "clrld");
    step(0, 0, 1, 0, 0, 4'd0,  4'd0, 1'b0, "hold");
    step(0, 1, 1, 0, 0, 4'd0,  4'd1, 1'b0, "turn_up");
    step(0, 1, 0, 0, 0, 4'd0,  4'd0, 1'b0, "turn_dn");
    step(0, 1, 0, 0, 0, 4'd0,  4'd9, 1'b1, "dnwrap");
    step(0, 1, 0, 0, 0, 4'd0,  4'd8, 1'b0, "dnafter");
    step(0, 0, 0, 0, 1, 4'd9,  4'd9, 1'b0, "ld9");
    step(0, 1, 1, 0, 0, 4'd0,  4'd0, 1'b1, "upwrap");
    step(0, 1, 1, 1, 0, 4'd0,  4'd0, 1'b0, "clr");

    // Saturating instance: up sticks at 9, down sticks at 0, no wrap
    do_reset("rstD");
    for (int i = 1; i <= 15; i++)
      step(1, 1, 1, 0, 0, 4'd0, (i < 9) ? 4'(i) : 4'd9, 1'b0,
           $sformatf("sup%0d", i));
    for (int i = 1; i <= 12; i++)
      step(1, 1, 0, 0, 0, 4'd0, (i < 9) ? 4'(9 - i) : 4'd0, 1'b0,
           $sformatf("sdn%0d", i));

    // Asynchronous reset mid-count at 6, then resume from 0
    do_reset("rstE");
    for (int i = 1; i <= 6; i++)
      step(0, 1, 1, 0, 0, 4'd0, 4'(i), 1'b0, $sformatf("mid%0d", i));
    do_reset("rstMid");
    step(0, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, "resume1");
    step(0, 1, 1, 0, 0, 4'd0, 4'd2, 1'b0, "resume2");

    // Full-range instance: 1..15, 0 (wrap), then down wrap to 15
    do_reset("rstF");
    for (int i = 1; i <= 16; i++)
      step(2, 1, 1, 0, 0, 4'd0, 4'(i % 16), i == 16, $sformatf("f%0d", i));
    step(2, 1, 0, 0, 0, 4'd0, 4'd15, 1'b1, "fdnwrap");
    step(2, 0, 0, 0, 1, 4'd15, 4'd15, 1'b0, "fld15");
    step(2, 1, 1, 0, 0, 4'd0, 4'd0, 1'b1, "fupwrap");
    // The reset lands while d2 still shows its wrap pulse; it must clear it.
    do_reset("rstWrap");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain.pending", 16'(sb_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
